// File: rtl/unary_stream_encoder.sv
// Binary-to-unary source stage feeding one operand of the unary multiplier.
// Accepts a magnitude over a valid/ready handshake, then emits INPUT_WIDTH
// serial bits whose count of ones equals the (saturated) magnitude, either in
// thermometer order (ones first) or spread evenly with a Bresenham accumulator.
module unary_stream_encoder #(
    parameter int unsigned INPUT_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] in_value,
    input  logic                   in_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   enable,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic                   busy,
    output logic                   done
);

    // FSM encoding
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StStream = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] FullScale    = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LastIdx      = COUNT_WIDTH'(INPUT_WIDTH - 1);
    localparam logic [COUNT_WIDTH:0]   FullScaleExt = (COUNT_WIDTH + 1)'(INPUT_WIDTH);

    logic [1:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] val_q, val_d;
    logic                   mode_q, mode_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic                   bit_out_q, bit_out_d;
    logic                   bit_valid_q, bit_valid_d;
    logic                   done_q, done_d;

    logic [COUNT_WIDTH-1:0] val_sat;
    logic [COUNT_WIDTH:0]   spread_sum;
    logic [COUNT_WIDTH:0]   spread_rem;
    logic                   spread_bit;
    logic                   therm_bit;

    // Saturate the incoming magnitude and evaluate both bit rules for index cnt
    always_comb begin
        val_sat    = (in_value > FullScale) ? FullScale : in_value;
        therm_bit  = (cnt_q < val_q);
        // One extra bit so acc + val cannot wrap before the compare
        spread_sum = {1'b0, acc_q} + {1'b0, val_q};
        spread_bit = (spread_sum >= FullScaleExt);
        spread_rem = spread_bit ? (spread_sum - FullScaleExt) : spread_sum;
    end

    // Next-state logic for the handshake / stream / done sequence
    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    val_d   = val_sat;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                // Stalled edges emit nothing and freeze the index and accumulator
                if (enable) begin
                    bit_out_d   = mode_q ? spread_bit : therm_bit;
                    bit_valid_d = 1'b1;
                    cnt_d       = cnt_q + COUNT_WIDTH'(1);
                    if (mode_q) begin
                        // Remainder is always below INPUT_WIDTH, so it fits
                        acc_d = spread_rem[COUNT_WIDTH-1:0];
                    end
                    if (cnt_q == LastIdx) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            val_q       <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
        end
    end

    // Handshake and status flags decode straight from the state
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        bit_out   = bit_out_q;
        bit_valid = bit_valid_q;
        done      = done_q;
    end

endmodule
